// File: rtl/regfile_pkg.sv
// Shared register-file widths and the queue entry layout, used by the write queue
// and by the register file it feeds.
package regfile_pkg;

    localparam int REG_W    = 32;
    localparam int REGNUM_W = 5;

    typedef struct packed {
        logic [REGNUM_W-1:0] regnum;
        logic [REG_W-1:0]    data;
    } wq_entry_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Bundle of the write-queue signals: upstream request, downstream register-file
// write port, pending-write lookup and occupancy.
interface regfile_write_queue_if #(
    parameter int DEPTH = 4
);
    import regfile_pkg::*;

    // Upstream: a request transfers on a rising edge where in_valid and in_ready are
    // both 1; in_ready never depends on in_valid or on a same-cycle pop. Downstream:
    // out_enable is the write strobe, and a write happens on every edge where it is 1.
    logic                     in_valid;
    logic                     in_ready;
    logic [REGNUM_W-1:0]      in_regnum;
    logic [REG_W-1:0]         in_data;
    logic                     out_enable;
    logic [REGNUM_W-1:0]      out_regnum;
    logic [REG_W-1:0]         out_data;
    logic                     out_stall;
    logic [REGNUM_W-1:0]      lk_regnum;
    logic                     lk_hit;
    logic [REG_W-1:0]         lk_data;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_regnum, in_data, out_stall, lk_regnum,
        input  in_ready, out_enable, out_regnum, out_data, lk_hit, lk_data, count
    );

    modport slave (
        input  in_valid, in_regnum, in_data, out_stall, lk_regnum,
        output in_ready, out_enable, out_regnum, out_data, lk_hit, lk_data, count
    );

endinterface

// File: rtl/wq_lookup.sv
// Youngest-match search over the queued writes, scanning from the head (oldest)
// toward the tail so that the last match found is the youngest.
module wq_lookup
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wq_entry_t [DEPTH-1:0]         i_entries,
    input  logic [DEPTH-1:0]              i_valid,
    input  logic [$clog2(DEPTH)-1:0]      i_rd_ptr,
    input  logic [REGNUM_W-1:0]           i_regnum,
    output logic                          o_hit,
    output logic [REG_W-1:0]              o_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_rd_ptr + PTR_W'(i);
            if (i_valid[w_idx] && (i_regnum != '0) && (i_entries[w_idx].regnum == i_regnum)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Circular write buffer in front of the register file: drops writes to r0, issues
// in FIFO order when the file is not stalled, and answers pending-write lookups.
module regfile_write_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_write_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wq_entry_t [DEPTH-1:0] r_mem;
    logic [DEPTH-1:0]      r_valid;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_empty;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    wq_entry_t             w_head;

    assign w_empty  = (r_count == '0);
    assign w_head   = r_mem[r_rd_ptr];

    // in_ready looks only at occupancy, so a full queue stays closed even while popping.
    assign bus.in_ready   = (r_count < CNT_W'(DEPTH));
    assign bus.out_enable = !w_empty && !bus.out_stall;
    assign bus.out_regnum = w_empty ? '0 : w_head.regnum;
    assign bus.out_data   = w_empty ? '0 : w_head.data;
    assign bus.count      = r_count;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_push   = w_accept && (bus.in_regnum != '0);
    assign w_pop    = bus.out_enable;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset: r_valid and r_count decide what is visible.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_regnum, bus.in_data};
        end
    end

    wq_lookup #(
        .DEPTH (DEPTH)
    ) u_lookup (
        .i_entries (r_mem),
        .i_valid   (r_valid),
        .i_rd_ptr  (r_rd_ptr),
        .i_regnum  (bus.lk_regnum),
        .o_hit     (bus.lk_hit),
        .o_data    (bus.lk_data)
    );

endmodule

// File: doc/regfile_write_queue.md
REGFILE_WRITE_QUEUE -- requirements
Module: regfile_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered write requests (power of two, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream write request present.
REQ-005 SHALL have port in_ready  output  1  queue can accept a request this cycle.
REQ-006 SHALL have port in_regnum  input  5  destination register number.
REQ-007 SHALL have port in_data  input  32  value to write.
REQ-008 SHALL have port out_enable  output  1  write strobe to the downstream 32-bit register file.
REQ-009 SHALL have port out_regnum  output  5  register number of the head entry.
REQ-010 SHALL have port out_data  output  32  data of the head entry.
REQ-011 SHALL have port out_stall  input  1  register file cannot take a write this cycle.
REQ-012 SHALL have port lk_regnum  input  5  register number for the pending-write lookup.
REQ-013 SHALL have port lk_hit  output  1  a queued write targets lk_regnum.
REQ-014 SHALL have port lk_data  output  32  data of the youngest matching queued write.
REQ-015 SHALL have port count  output  clog2(DEPTH)+1  number of entries held.

Function
REQ-016 SHALL accept a request at a rising edge when in_valid=1, in_ready=1 and reset=1.
REQ-017 SHALL drive in_ready = (count < DEPTH), independent of out_stall and of any same-cycle pop (no full-queue bypass).
REQ-018 SHALL discard accepted requests with in_regnum=0: handshake completes, count unchanged.
REQ-019 SHALL store entries in a circular buffer; read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-020 SHALL drive out_enable = (count != 0) && !out_stall, combinationally from registered state only.
REQ-021 SHALL pop the head at a rising edge where out_enable=1.
REQ-022 SHALL present a request pushed into an empty queue on out_* in the next cycle (latency 1, no same-cycle pass-through).
REQ-023 SHALL drive out_regnum=0 and out_data=0 when count=0.
REQ-024 SHALL, on simultaneous push and pop, keep count unchanged and preserve FIFO order.
REQ-025 SHALL hold head entry and out_* stable while out_stall=1.
REQ-026 SHALL compute lk_hit/lk_data combinationally over valid entries only, youngest match winning.
REQ-027 SHALL drive lk_hit=0, lk_data=0 on a miss or when lk_regnum=0.
REQ-028 SHALL exclude from lookup an entry popped in the current cycle only from the next cycle onward (lookup reflects registered state).

Reset
REQ-029 SHALL, at a rising edge with reset=0, clear count and both pointers, invalidate all entries, ignore in_valid and out_enable.
REQ-030 SHALL, in the cycle after reset, show count=0, in_ready=1, out_enable=0, out_regnum=0, out_data=0, lk_hit=0.
REQ-031 SHALL, if reset is asserted mid-operation, drop all pending writes without issuing them.

Structure
REQ-032 SHALL take REG_W=32 and REGNUM_W=5 from shared package regfile_pkg, also used by the register file.
REQ-033 SHALL place the youngest-match lookup in one sub-module, wq_lookup, combinational, parameterised by DEPTH.
REQ-034 SHALL contain no latches; all state updates on posedge clk only.

Verification
REQ-035 SHALL cover: after reset, push r2=88 -> next cycle out_enable=1, out_regnum=2, out_data=88; following cycle count=0.
REQ-036 SHALL cover: out_stall=1, push r1..r4 = 11..14 -> count=4, in_ready=0, 5th request held; release stall -> writes issue 11,12,13,14 in order.
REQ-037 SHALL cover: stall, push r5=10 then r5=20, lk_regnum=5 -> lk_hit=1, lk_data=20; lk_regnum=6 -> lk_hit=0, lk_data=0.
REQ-038 SHALL cover: push r0=7 -> in_ready handshake completes, count stays 0, out_enable never 1.
REQ-039 SHALL cover: count=2, simultaneous push r3=33 and pop -> count=2, r3=33 issued after remaining older entry.
REQ-040 SHALL cover: 3 entries queued, reset=0 for one cycle -> count=0, out_enable=0, no further writes issued; wrap-around after 6 push/pop pairs preserves order.
